// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 followed by per-round C/D rotations, one C||D word per round on a valid/ready stream.
// Optional key-parity flag under DES_KS_PARITY_EN (advisory only; schedule runs regardless).

module des_ks_rot (
    input  logic [27:0] din,
    input  logic        right,
    input  logic        two,
    output logic [27:0] dout
);
    // Index i holds FIPS bit i+1, so a FIPS left rotate moves bits toward index 0.
    always_comb begin
        dout = din;
        case ({right, two})
            2'b00:   dout = {din[0],    din[27:1]};
            2'b01:   dout = {din[1:0],  din[27:2]};
            2'b10:   dout = {din[26:0], din[27]};
            2'b11:   dout = {din[25:0], din[27:26]};
            default: dout = din;
        endcase
    end
endmodule

module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [55:0] cd_out,
    output logic [3:0]  round_idx,
    output logic        cd_valid,
    input  logic        cd_ready,
    output logic        sched_done,
    output logic        parity_err
);
    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    // Rounds whose shift is 1 (table positions 0, 1, 8, 15); all others shift by 2.
    localparam logic [15:0] SHIFT_ONE = 16'h8103;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic        mode_q;
    logic        load, step;
    logic [55:0] pc1_key, load_cd, step_cd;
    logic [3:0]  tbl_idx;
    logic        step_two;

    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign pc1_key[i] = key_in[PC1[i]-1];
    end

    // Parity bits never reach PC-1; collect them so they are visibly intentional.
    logic [7:0] par_bits;
    logic       par_bits_unused;
    for (genvar k = 0; k < 8; k++) begin : g_par
        assign par_bits[k] = key_in[8*k+7];
    end
    assign par_bits_unused = ^par_bits;

    assign tbl_idx  = mode_q ? (4'd15 - round_idx) : (round_idx + 4'd1);
    assign step_two = ~SHIFT_ONE[tbl_idx];

    for (genvar h = 0; h < 2; h++) begin : g_half
        des_ks_rot u_load (
            .din   (pc1_key[h*28 +: 28]),
            .right (1'b0),
            .two   (1'b0),
            .dout  (load_cd[h*28 +: 28])
        );
        des_ks_rot u_step (
            .din   (cd_out[h*28 +: 28]),
            .right (mode_q),
            .two   (step_two),
            .dout  (step_cd[h*28 +: 28])
        );
    end

    assign load = key_valid && key_ready;
    assign step = cd_valid && cd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = RUN;
            RUN:     if (step && round_idx == 4'd15) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        key_ready = (state == IDLE);
        cd_valid  = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cd_out     <= '0;
            round_idx  <= '0;
            mode_q     <= 1'b0;
            sched_done <= 1'b0;
        end else begin
            sched_done <= 1'b0;
            if (load) begin
                // Decrypt starts at C16||D16, which equals PC1(key) since total rotation is 28.
                cd_out    <= decrypt ? pc1_key : load_cd;
                round_idx <= '0;
                mode_q    <= decrypt;
            end else if (step) begin
                if (round_idx == 4'd15) begin
                    sched_done <= 1'b1;
                end else begin
                    cd_out    <= step_cd;
                    round_idx <= round_idx + 4'd1;
                end
            end
        end
    end

`ifdef DES_KS_PARITY_EN
    logic key_par_bad;
    always_comb begin
        key_par_bad = 1'b0;
        for (int k = 0; k < 8; k++)
            if (~^key_in[8*k +: 8]) key_par_bad = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)    parity_err <= 1'b0;
        else if (load) parity_err <= key_par_bad;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomized and directed bench for des_key_schedule against a FIPS-table reference model.

module tb_des_key_schedule;
    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] key_in;
    logic        decrypt;
    logic        key_valid;
    logic        key_ready;
    logic [55:0] cd_out;
    logic [3:0]  round_idx;
    logic        cd_valid;
    logic        cd_ready;
    logic        sched_done;
    logic        parity_err;

    int n_chk  = 0;
    int n_fail = 0;
    logic [55:0] got [16];

    des_key_schedule dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .decrypt    (decrypt),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .cd_out     (cd_out),
        .round_idx  (round_idx),
        .cd_valid   (cd_valid),
        .cd_ready   (cd_ready),
        .sched_done (sched_done),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = v[63-i];
        return r;
    endfunction

    function automatic logic [27:0] rev28(input logic [27:0] v);
        logic [27:0] r;
        for (int i = 0; i < 28; i++) r[i] = v[27-i];
        return r;
    endfunction

    // C_n / D_n are C_0 / D_0 rotated left by the cumulative shift count up to round n.
    function automatic logic [55:0] model_cd(input logic [63:0] kv, input int rnd);
        int          tot;
        logic [27:0] c, d;
        logic [55:0] r;
        tot = 0;
        for (int i = 0; i < rnd; i++) tot += SHIFTS[i];
        for (int j = 0; j < 28; j++) begin
            c[j] = kv[PC1[j]-1];
            d[j] = kv[PC1[28+j]-1];
        end
        for (int j = 0; j < 28; j++) begin
            r[j]    = c[(j + tot) % 28];
            r[28+j] = d[(j + tot) % 28];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2_hex(input logic [55:0] cd);
        logic [47:0] k;
        for (int j = 0; j < 48; j++) k[47-j] = cd[PC2[j]-1];
        return k;
    endfunction

    function automatic logic model_par(input logic [63:0] kv);
`ifdef DES_KS_PARITY_EN
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 8; k++)
            if (~^kv[8*k +: 8]) bad = 1'b1;
        return bad;
`else
        return 1'b0;
`endif
    endfunction

    // stall_mode: 0 always ready, 1 stall 3 cycles on words 0/5/15, 2 random ready.
    task automatic run_sched(input logic [63:0] kv, input logic dec, input int stall_mode,
                             input bit inject);
        int   cnt, cycles, stall;
        logic rdy;
        int   wait_cyc;
        wait_cyc = 0;
        while (!key_ready && wait_cyc < 50) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        chk("key_ready_idle", key_ready, 1'b1);
        key_in    = kv;
        decrypt   = dec;
        key_valid = 1'b1;
        cd_ready  = 1'b0;
        @(posedge clk); #1;
        key_valid = 1'b0;
        chk("load_valid", cd_valid, 1'b1);
        chk("load_parity", parity_err, model_par(kv));
        cnt = 0; cycles = 0; stall = 0;
        while (cnt < 16 && cycles < 400) begin
            chk("idx", round_idx, cnt);
            chk("cd", cd_out, model_cd(kv, dec ? 16 - cnt : cnt + 1));
            chk("no_key_ready", key_ready, 1'b0);
            got[cnt] = cd_out;
            if (stall_mode == 1)
                rdy = !((cnt == 0 || cnt == 5 || cnt == 15) && stall < 3);
            else if (stall_mode == 2)
                rdy = ($urandom_range(3) != 0);
            else
                rdy = 1'b1;
            cd_ready = rdy;
            if (inject && cnt >= 3 && cnt < 8) begin
                key_valid = 1'b1;
                key_in    = ~kv;
                decrypt   = ~dec;
            end else begin
                key_valid = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
            if (rdy) begin
                cnt++;
                stall = 0;
            end else begin
                stall++;
            end
            chk("done_pulse", sched_done, cnt == 16 && rdy);
        end
        key_valid = 1'b0;
        cd_ready  = 1'b0;
        chk("transfers", cnt, 16);
        chk("end_valid", cd_valid, 1'b0);
        chk("end_key_ready", key_ready, 1'b1);
        chk("end_hold", cd_out, model_cd(kv, dec ? 1 : 16));
        chk("end_parity", parity_err, model_par(kv));
        @(posedge clk); #1;
        chk("done_once", sched_done, 1'b0);
    endtask

    initial begin
        logic [63:0] tkey;
        logic [63:0] rk;
        int          cyc;
        rst_n = 1'b0; key_in = '0; decrypt = 1'b0; key_valid = 1'b0; cd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", cd_valid, 1'b0);
        chk("rst_ready", key_ready, 1'b1);
        chk("rst_cd", cd_out, 56'd0);
        chk("rst_idx", round_idx, 4'd0);
        chk("rst_done", sched_done, 1'b0);
        chk("rst_par", parity_err, 1'b0);
        rst_n = 1'b1;

        tkey = rev64(64'h133457799BBCDFF1);

        run_sched(tkey, 1'b0, 0, 1'b0);
        chk("t1_w0_c", rev28(got[0][27:0]), 28'hE19955F);
        chk("t1_w0_d", rev28(got[0][55:28]), 28'hAACCF1E);
        chk("t1_k1", pc2_hex(got[0]), 48'h1B02EFFC7072);
        chk("t1_w15_c", rev28(got[15][27:0]), 28'hF0CCAAF);
        chk("t1_w15_d", rev28(got[15][55:28]), 28'h556678F);

        run_sched(tkey, 1'b1, 0, 1'b0);
        chk("t2_w0_c", rev28(got[0][27:0]), 28'hF0CCAAF);
        chk("t2_w0_d", rev28(got[0][55:28]), 28'h556678F);
        chk("t2_w15_c", rev28(got[15][27:0]), 28'hE19955F);
        chk("t2_w15_d", rev28(got[15][55:28]), 28'hAACCF1E);

        run_sched(tkey, 1'b0, 1, 1'b0);
        run_sched(tkey, 1'b1, 1, 1'b0);
        run_sched(tkey, 1'b0, 0, 1'b1);
        run_sched(rev64(64'h0101010101010101), 1'b0, 0, 1'b0);

        // Abort mid-run at round 7, then restart.
        key_in = tkey; decrypt = 1'b0; key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0; cd_ready = 1'b1;
        cyc = 0;
        while (round_idx != 4'd7 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t5_reach7", round_idx, 4'd7);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; cd_ready = 1'b0;
        chk("t5_valid", cd_valid, 1'b0);
        chk("t5_ready", key_ready, 1'b1);
        chk("t5_idx", round_idx, 4'd0);
        chk("t5_cd", cd_out, 56'd0);
        chk("t5_par", parity_err, 1'b0);
        run_sched(tkey, 1'b0, 0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            rk = {$urandom, $urandom};
            run_sched(rk, n[0], 2, n % 3 == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
